// File: rtl/serial_deserializer.sv
// Purpose: serial-in, parallel-out frame receiver (MSB- or LSB-first) with a valid/ready word register.
// Latency: p_valid rises 1 cycle after the N-th bit is sampled; back-to-back frames need no gap.
// Backpressure: a word completing while p_valid & !p_ready is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   s_in/s_valid   serial bit and its qualifier
//   s_start        marks bit 0 of a new frame
//   dir            0 = MSB-first, 1 = LSB-first (sampled with the start bit)
//   p_out/p_valid  completed word and its valid flag
//   p_ready        consumer accepts p_out when p_valid & p_ready
//   busy, bit_cnt  frame in progress and bits captured so far
//   overrun        sticky: a completed word was dropped
//   frame_err      sticky: s_start arrived mid-frame
//   clr_err        clears both sticky flags (a simultaneous set wins)
module serial_deserializer #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_in,
  input  logic          s_valid,
  input  logic          s_start,
  input  logic          dir,
  output logic [N-1:0]  p_out,
  output logic          p_valid,
  input  logic          p_ready,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun,
  output logic          frame_err,
  input  logic          clr_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   shift_reg;
  logic [N-1:0]   shift_base;
  logic [N-1:0]   shift_nxt;
  logic           dir_l;
  logic           dir_eff;
  logic           accept_start;
  logic           accept_bit;
  logic           complete;
  logic           ferr_set;
  logic           ovr_set;

  // A start bit is honoured in any state; a mid-frame start restarts the frame.
  assign accept_start = s_valid & s_start;
  assign accept_bit   = s_valid & ~s_start & (state == SHIFT);
  assign complete     = accept_bit & (bit_cnt == CW'(N - 1));
  assign ferr_set     = accept_start & (state == SHIFT);
  assign ovr_set      = complete & p_valid & ~p_ready;

  // The start bit uses the freshly sampled dir and discards any partial word.
  assign dir_eff    = accept_start ? dir : dir_l;
  assign shift_base = accept_start ? '0 : shift_reg;
  assign shift_nxt  = dir_eff ? {s_in, shift_base[N-1:1]}
                              : {shift_base[N-2:0], s_in};

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (accept_start)  state_nxt = SHIFT;
    else if (complete) state_nxt = IDLE;
  end

  // Output logic (decoded from the state register, so still glitch-free registered timing)
  always_comb begin
    busy = (state == SHIFT);
  end

  // Datapath: shift register, bit counter, latched direction
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      dir_l     <= 1'b0;
    end else begin
      if (accept_start) dir_l <= dir;
      if (accept_start || accept_bit) shift_reg <= shift_nxt;
      if (accept_start)    bit_cnt <= CW'(1);
      else if (complete)   bit_cnt <= '0;
      else if (accept_bit) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // Output word register
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_out   <= '0;
      p_valid <= 1'b0;
    end else if (complete && (!p_valid || p_ready)) begin
      p_out   <= shift_nxt;
      p_valid <= 1'b1;
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

  // Sticky flags: set has priority over clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Purpose: self-checking bench for serial_deserializer (directed scenarios plus random traffic).
// Latency: every step drives one cycle of inputs and compares all outputs #1 after the edge.
// Backpressure: p_ready is driven per step, both held and randomised.
module tb_serial_deserializer;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst, s_in, s_valid, s_start, dir, p_ready, clr_err;
  logic [N-1:0]  p_out;
  logic          p_valid, busy, overrun, frame_err;
  logic [CW-1:0] bit_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the frame in progress is a list of received bits,
  // the word is assembled by positional arithmetic once N bits are present.
  int           m_bits[$];
  logic         m_dir;
  logic [N-1:0] m_pout;
  logic         m_pv, m_ovr, m_ferr;

  serial_deserializer #(.N(N)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .dir(dir), .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready),
    .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun), .frame_err(frame_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic b, v, st, d, pr, clr, r);
    logic         cmp;
    logic         ferr_set, ovr_set;
    logic [N-1:0] word;
    cmp = 1'b0; ferr_set = 1'b0; ovr_set = 1'b0; word = '0;
    if (!r) begin
      m_bits.delete();
      m_dir = 1'b0; m_pout = '0; m_pv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    end else begin
      if (v && st) begin
        if (m_bits.size() > 0) ferr_set = 1'b1;
        m_bits.delete();
        m_bits.push_back(int'(b));
        m_dir = d;
      end else if (v && m_bits.size() > 0) begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == N) begin
          for (int i = 0; i < N; i++) begin
            // bit i of the stream lands at position i (LSB-first) or N-1-i (MSB-first)
            if (m_dir) word[i]       = m_bits[i][0];
            else       word[N-1-i]   = m_bits[i][0];
          end
          cmp = 1'b1;
          m_bits.delete();
        end
      end
      if (cmp) begin
        if (!m_pv || pr) begin m_pout = word; m_pv = 1'b1; end
        else ovr_set = 1'b1;
      end else if (m_pv && pr) begin
        m_pv = 1'b0;
      end
      if (ovr_set)  m_ovr  = 1'b1; else if (clr) m_ovr  = 1'b0;
      if (ferr_set) m_ferr = 1'b1; else if (clr) m_ferr = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("p_valid",   {31'd0, p_valid},   {31'd0, m_pv});
    chk("p_out",     {24'd0, p_out},     {24'd0, m_pout});
    chk("busy",      {31'd0, busy},      {31'd0, (m_bits.size() > 0)});
    chk("bit_cnt",   {28'd0, bit_cnt},   m_bits.size());
    chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  task automatic step(input logic b, v, st, d, pr, clr, r);
    s_in = b; s_valid = v; s_start = st; dir = d; p_ready = pr; clr_err = clr; rst = r;
    @(posedge clk);
    model_update(b, v, st, d, pr, clr, r);
    #1;
    compare_all();
  endtask

  // Sends one frame; stream[N-1] goes out first. Optional dir toggling after the start bit
  // and optional idle gaps (s_valid=0) between bits.
  task automatic send_stream(input logic [N-1:0] stream, input logic d, input logic pr,
                             input logic toggle_dir, input logic gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 1) == 1)
        step(1'b1, 1'b0, 1'b1, ~d, pr, 1'b0, 1'b1);
      step(stream[N-1-i], 1'b1, (i == 0), (toggle_dir && i > 0) ? ~d : d, pr, 1'b0, 1'b1);
    end
  endtask

  task automatic idle(input logic pr, input logic clr);
    step(1'b0, 1'b0, 1'b0, 1'b0, pr, clr, 1'b1);
  endtask

  initial begin
    m_bits.delete();
    m_dir = 1'b0; m_pout = '0; m_pv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    s_in = 1'b0; s_valid = 1'b0; s_start = 1'b0; dir = 1'b0;
    p_ready = 1'b0; clr_err = 1'b0; rst = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pvalid", {31'd0, p_valid}, 32'd0);
    chk("rst_bitcnt", {28'd0, bit_cnt}, 32'd0);

    // 1: MSB-first 1,0,1,1,0,0,1,0
    send_stream(8'b1011_0010, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_pout",   {24'd0, p_out},   32'hB2);
    chk("t1_pvalid", {31'd0, p_valid}, 32'd1);

    // 2: same bits LSB-first, with dir toggling after the start bit
    send_stream(8'b1011_0010, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_pout", {24'd0, p_out}, 32'h4D);

    // 3: back-to-back frames, consumer always ready
    send_stream(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_first", {24'd0, p_out}, 32'hA5);
    send_stream(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_second",  {24'd0, p_out},   32'h3C);
    chk("t3_overrun", {31'd0, overrun}, 32'd0);
    idle(1'b1, 1'b0);

    // 4: consumer stalled across two frames, then clear
    send_stream(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_stream(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_pout",    {24'd0, p_out},   32'h11);
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    idle(1'b0, 1'b1);
    chk("t4_clr", {31'd0, overrun}, 32'd0);
    idle(1'b1, 1'b0);

    // 5: restart after 3 bits, then 0xF0 with gaps in s_valid
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_stream(8'hF0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_ferr", {31'd0, frame_err}, 32'd1);
    chk("t5_pout", {24'd0, p_out},     32'hF0);

    // 6: reset mid-frame, then non-start bits are ignored
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, (i == 0), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_pout", {24'd0, p_out},     32'd0);
    chk("t6_ferr", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_busy", {31'd0, busy}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(logic'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 299) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
